seq_detector_1011: RTL and testbench



---
 rtl/seq_detector_1011_pkg.sv | 29 ++
 rtl/seq_detector_1011_if.sv | 26 ++
 rtl/seq_detector_1011_sat_counter.sv | 40 ++++
 rtl/seq_detector_1011.sv | 51 +++++
 tb/tb_seq_detector_1011.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/seq_detector_1011_pkg.sv
// Shared state encoding and transition rule for the 1011 detector.
`timescale 1ns/1ps

package seq_detector_1011_pkg;

    localparam int unsigned STATE_W = 3;

    // S0 no prefix, S1 "1", S2 "10", S3 "101", S4 "1011" (match)
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;

    // Overlapping transition rule; codes 5..7 fall back to S0.
    function automatic state_t next_state(input state_t s, input logic d);
        case (s)
            S0:      return d ? S1 : S0;
            S1:      return d ? S1 : S2;
            S2:      return d ? S3 : S0;
            S3:      return d ? S4 : S2;
            S4:      return d ? S1 : S2;
            default: return S0;
        endcase
    endfunction

endpackage

// File: rtl/seq_detector_1011_if.sv
// Bus between the 1011 detector and its stimulus/status neighbours.
`timescale 1ns/1ps

interface seq_detector_1011_if #(
    parameter int CNT_WIDTH = 4
);
    import seq_detector_1011_pkg::*;

    logic                 En;
    logic                 D;
    logic                 Clr;
    logic                 Match;
    logic [STATE_W-1:0]   State;
    logic [CNT_WIDTH-1:0] Count;
    logic                 Sat;

    modport master (
        output En, D, Clr,
        input  Match, State, Count, Sat
    );

    modport slave (
        input  En, D, Clr,
        output Match, State, Count, Sat
    );
endinterface

// File: rtl/seq_detector_1011_sat_counter.sv
// Saturating match counter; a synchronous clear overrides a same-edge increment.
`timescale 1ns/1ps

module sat_counter #(
    parameter int CNT_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Inc,
    input  logic                 Clr,
    output logic [CNT_WIDTH-1:0] Count,
    output logic                 Sat
);

    localparam logic [CNT_WIDTH-1:0] MAX = '1;

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_sat;
    logic [CNT_WIDTH-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_WIDTH'(1);

    // Count up to all ones and hold; Sat is registered alongside the count.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (Clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (Inc && !r_sat) begin
            r_count <= w_count_inc;
            r_sat   <= (w_count_inc == MAX);
        end
    end

    assign Count = r_count;
    assign Sat   = r_sat;

endmodule

// File: rtl/seq_detector_1011.sv
// Moore detector for serial pattern 1011 with overlap, plus a saturating match count.
`timescale 1ns/1ps

module seq_detector_1011
    import seq_detector_1011_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    seq_detector_1011_if.slave  bus
);

    state_t r_state;
    logic   r_match;
    state_t w_next;
    logic   w_inc;

    // Next state from the shared transition rule.
    always_comb begin
        w_next = next_state(r_state, bus.D);
    end

    assign w_inc = bus.En && (w_next == S4);

    // State register with Match registered as the S4 decode of the next state.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S0;
            r_match <= 1'b0;
        end else if (bus.En) begin
            r_state <= w_next;
            r_match <= (w_next == S4);
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_sat_counter (
        .Clk   (Clk),
        .Rst   (Rst),
        .Inc   (w_inc),
        .Clr   (bus.Clr),
        .Count (bus.Count),
        .Sat   (bus.Sat)
    );

    assign bus.State = r_state;
    assign bus.Match = r_match;

endmodule

// File: tb/tb_seq_detector_1011.sv
// Self-checking bench for seq_detector_1011 against a suffix-matching reference.
`timescale 1ns/1ps

module tb_seq_detector_1011;

    localparam int CW  = 2;
    localparam int MAX = (1 << CW) - 1;

    logic Clk;
    logic Rst;

    int checks   = 0;
    int failures = 0;

    // Reference: last enabled bits since reset, and a plain integer count.
    int hist[$];
    int pat[4] = '{1, 0, 1, 1};
    int mcount;

    seq_detector_1011_if #(.CNT_WIDTH(CW)) bus_if ();

    seq_detector_1011 #(.CNT_WIDTH(CW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Longest suffix of the history that is a prefix of 1011.
    function automatic int model_state();
        for (int len = 4; len >= 1; len--) begin
            if (hist.size() >= len) begin
                bit ok = 1'b1;
                for (int k = 0; k < len; k++)
                    if (hist[hist.size() - len + k] != pat[k]) ok = 1'b0;
                if (ok) return len;
            end
        end
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int s;
        int c;
        s = model_state();
        c = (mcount > MAX) ? MAX : mcount;
        check({tag, ".state"}, 32'(bus_if.State), 32'(s));
        check({tag, ".match"}, 32'(bus_if.Match), 32'(s == 4));
        check({tag, ".count"}, 32'(bus_if.Count), 32'(c));
        check({tag, ".sat"},   32'(bus_if.Sat),   32'(c == MAX));
    endtask

    // Called at a negedge: apply inputs, take one rising edge, check #1 later.
    task automatic step(input string tag, input logic en, input logic d, input logic clr);
        bus_if.En  = en;
        bus_if.D   = d;
        bus_if.Clr = clr;
        @(posedge Clk);
        if (en) begin
            hist.push_back(int'(d));
            if (hist.size() > 4) void'(hist.pop_front());
        end
        if (clr) mcount = 0;
        else if (en && model_state() == 4 && mcount < MAX) mcount++;
        #1;
        check_all(tag);
        @(negedge Clk);
    endtask

    // Called at a negedge: assert Rst mid-cycle, check immediately, release at next negedge.
    task automatic do_reset(input string tag);
        #2;
        Rst = 1'b1;
        hist.delete();
        mcount = 0;
        #1;
        check_all(tag);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic send_bits(input string tag, input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            step($sformatf("%s[%0d]", tag, n - 1 - i), 1'b1, bits[i], 1'b0);
    endtask

    initial begin
        Rst        = 1'b1;
        bus_if.En  = 1'b0;
        bus_if.D   = 1'b0;
        bus_if.Clr = 1'b0;
        mcount     = 0;
        @(negedge Clk);
        check_all("por");
        Rst = 1'b0;

        // Mid-cycle reset and idle zeros
        do_reset("rst_async");
        for (int i = 0; i < 8; i++) step($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0);

        // Basic and overlap: 1011011
        send_bits("ovl", 16'b1011011, 7);
        check("ovl.count2", 32'(bus_if.Count), 32'd2);

        // Non-match and partial: 100101011
        do_reset("rst_b");
        send_bits("part", 16'b100101011, 9);
        check("part.count1", 32'(bus_if.Count), 32'd1);

        // Enable gating across a partial pattern
        do_reset("rst_c");
        send_bits("gate_pre", 16'b101, 3);
        for (int i = 0; i < 3; i++) step($sformatf("gate_hold%0d", i), 1'b0, 1'b0, 1'b0);
        step("gate_last", 1'b1, 1'b1, 1'b0);
        check("gate.match", 32'(bus_if.Match), 32'd1);

        // Hold in S4 with En low keeps Match high
        step("hold_s4", 1'b0, 1'b0, 1'b0);

        // Saturation then clear coincident with a match edge
        do_reset("rst_d");
        for (int r = 0; r < 5; r++) send_bits($sformatf("sat%0d", r), 16'b1011, 4);
        check("sat.count", 32'(bus_if.Count), 32'(MAX));
        send_bits("clr_pre", 16'b01, 2);
        step("clr_match", 1'b1, 1'b1, 1'b1);
        check("clr.count0", 32'(bus_if.Count), 32'd0);

        // Clear with En low still clears
        step("inc_after_clr", 1'b1, 1'b0, 1'b0);
        send_bits("inc2", 16'b11, 2);
        step("clr_noen", 1'b0, 1'b0, 1'b1);

        // Reset mid-pattern discards prefix
        do_reset("rst_e");
        send_bits("mid_pre", 16'b101, 3);
        do_reset("rst_mid");
        step("mid_post", 1'b1, 1'b1, 1'b0);
        check("mid.state1", 32'(bus_if.State), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                do_reset($sformatf("rnd_rst%0d", i));
            end else begin
                step($sformatf("rnd%0d", i),
                     logic'($urandom_range(9) != 0),
                     logic'($urandom_range(1)),
                     logic'($urandom_range(29) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
